coriolis_stream_sink: RTL and testbench
=======================================

# coriolis_stream_sink

Terminal collector for a kernel output stream. Accepts 34-bit FloPoCo-format words (2-bit exception field plus IEEE-754 single) from the last leaf map node over the valid/ready handshake, and converts each to plain IEEE-754 single. Buffers results in a small FIFO for the host-side drain port. Counts elements, raises `done` after a programmed number have drained, and keeps sticky NaN/Inf flags.

## Interface
- `STREAMW`, 34: input word width (`[33:32]` FloPoCo exception field, `[31:0]` IEEE bits).
- `DATAW`, 32: output word width.
- `DEPTH`, 8: FIFO depth; must be a power of 2, at least 2.
- `NELEM`, 1024: number of elements per run; must be at least 1.
- Reset: one clock; reset is synchronous and active-low. The port is named `rst`; `rst==0` at a rising `clk` edge resets the block.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-low reset.
- `ivalid` in 1: upstream word valid (driven by upstream `ovalid`).
- `in1` in STREAMW: upstream data.
- `iready` out 1: sink can accept a word (drives upstream `oready`).
- `ovalid` out 1: drain-side word available.
- `out1` out DATAW: converted IEEE word, valid while `ovalid`=1.
- `oready` in 1: drain side accepts.
- `count` out 32: words accepted since reset.
- `done` out 1: NELEM words have been drained.
- `nan_seen` out 1: sticky; a NaN has been accepted.
- `inf_seen` out 1: sticky; an Inf has been accepted.

## Operation
- Write: a word is accepted when `ivalid & iready` is high at a rising edge.
- `iready = !full & (count < NELEM)`. It is combinational from registered state only and never depends on `ivalid`.
- Conversion applies at write time. Sign `s = in1[31]`. The exception field maps as follows:
  - `00` → `{s, 31'b0}` (signed zero).
  - `01` → `in1[31:0]` unchanged.
  - `10` → `{s, 8'hFF, 23'b0}`.
  - `11` → `32'h7FC00000` (canonical quiet NaN).
- Flags: `nan_seen` sets on an accepted `11` word, and `inf_seen` sets on an accepted `10` word. Both hold until reset.
- FIFO: first-word-fall-through. A read occurs when `ovalid & oready`. `ovalid = !empty`.
- Simultaneous read and write:
  - When neither full nor empty, occupancy is unchanged.
  - When full, `iready`=0, so no write occurs even if a read happens in the same cycle.
  - When empty, there is no bypass; the written word appears the next cycle.
- Pointers: read and write pointers are log2(DEPTH)+1 bits and wrap naturally. `full` means the MSBs differ and the rest are equal; `empty` means the pointers are equal.
- `count` increments on each write and saturates at NELEM.
- A separate drain counter increments on each read. `done` registers high on the cycle after the NELEM-th read and stays high until reset.
- Once `count == NELEM`, further upstream words are not accepted. `iready` stays 0 until reset.

## Timing
- Reset values:
  - `iready`=1 (the cycle after reset is released).
  - `ovalid`=0, `out1`=0, `count`=0, `done`=0, `nan_seen`=0, `inf_seen`=0.
  - Pointers are 0.
- Write-to-`ovalid` latency is 1 cycle when the FIFO is empty.
- Throughput is 1 word per cycle with `oready` held high.
- `done` rises 1 cycle after the final read handshake.
- Reset mid-run: the FIFO contents are discarded and every counter and flag clears on the same edge. Stored data is not required to clear.
- No combinational path from `ivalid` to `iready`, or from `oready` to `ovalid`.

## Structure
- Package `coriolis_stream_pkg` holds:
  - exception codes `EXN_ZERO=2'b00`, `EXN_NORMAL=2'b01`, `EXN_INF=2'b10`, `EXN_NAN=2'b11`;
  - `CANON_NAN=32'h7FC00000`;
  - the pure function `fpc_to_ieee(34-bit) → 32-bit`.
- Sub-module `coriolis_sink_fifo`: parameterised synchronous FWFT FIFO (DATAW, DEPTH) with full/empty outputs. The top level holds conversion, counters, flags and `done`.

## Test plan
- Normal passthrough: `in1={2'b01,32'hbd80ae10}` with `oready`=1 → `out1=32'hbd80ae10` one cycle later; `count`=1; flags stay 0.
- Exception mapping: write `{00, 32'h80001234}`, `{10, 32'h80000000}`, `{11, 32'h00000001}` → `out1` is `32'h80000000`, `32'hFF800000`, `32'h7FC00000` in order; `inf_seen`=1 and `nan_seen`=1 after the respective accepts.
- Backpressure: `oready`=0, `ivalid`=1 continuously, DEPTH=8 → exactly 8 accepts, then `iready`=0. Raise `oready` → one read per cycle, `iready` returns 1 the cycle after the first read, and word order is preserved.
- Completion: NELEM=4, 6 words offered → `count` saturates at 4 and `iready` stays 0. After 4 reads, `done`=1 on the next cycle and holds.
- Simultaneous read/write: occupancy 3, `ivalid`=1 and `oready`=1 for 10 cycles → occupancy stays 3 and the output sequence matches the input order.
- Mid-run reset: 5 words buffered, then `rst`=0 for one cycle → next cycle `ovalid`=0, `count`=0, flags 0, `iready`=1. The following accepted word emerges first.

Source files
------------

// File: rtl/coriolis_stream_pkg.sv
// Shared definitions for the coriolis stream sink: FloPoCo exception codes and
// the FloPoCo-to-IEEE-754 single conversion.
package coriolis_stream_pkg;

    localparam logic [1:0]  EXN_ZERO   = 2'b00;
    localparam logic [1:0]  EXN_NORMAL = 2'b01;
    localparam logic [1:0]  EXN_INF    = 2'b10;
    localparam logic [1:0]  EXN_NAN    = 2'b11;

    localparam logic [31:0] CANON_NAN  = 32'h7FC00000;

    // The exception field overrides the IEEE payload except for normal numbers.
    function automatic logic [31:0] fpc_to_ieee(input logic [33:0] word);
        logic [31:0] res;
        res = CANON_NAN;
        unique case (word[33:32])
            EXN_ZERO:   res = {word[31], 31'b0};
            EXN_NORMAL: res = word[31:0];
            EXN_INF:    res = {word[31], 8'hFF, 23'b0};
            EXN_NAN:    res = CANON_NAN;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/coriolis_sink_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers; the head
// word is presented combinationally and reads as zero while empty.
module coriolis_sink_fifo #(
    parameter int unsigned DATAW = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [DATAW-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [DATAW-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i && !full_o) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_en_i && !empty_o) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define contents.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/coriolis_stream_sink.sv
// Terminal sink: converts FloPoCo words to IEEE single, buffers them for the
// drain port, counts accepted/drained elements and keeps sticky NaN/Inf flags.
module coriolis_stream_sink
    import coriolis_stream_pkg::*;
#(
    parameter int unsigned STREAMW = 34,
    parameter int unsigned DATAW   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NELEM   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] in1,
    output logic               iready,
    output logic               ovalid,
    output logic [DATAW-1:0]   out1,
    input  logic               oready,
    output logic [31:0]        count,
    output logic               done,
    output logic               nan_seen,
    output logic               inf_seen
);

    localparam logic [31:0] NelemW = 32'(NELEM);

    logic        full, empty;
    logic        wr_en, rd_en;
    logic [31:0] count_q, count_d;
    logic [31:0] drain_q, drain_d;
    logic        done_q, done_d;
    logic        nan_q, nan_d;
    logic        inf_q, inf_d;

    // Both handshake readies come only from registered state.
    assign iready = !full && (count_q < NelemW);
    assign ovalid = !empty;
    assign wr_en  = ivalid && iready;
    assign rd_en  = oready && ovalid;

    coriolis_sink_fifo #(
        .DATAW (DATAW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (fpc_to_ieee(in1)),
        .rd_en_i   (rd_en),
        .rd_data_o (out1),
        .full_o    (full),
        .empty_o   (empty)
    );

    always_comb begin
        count_d = count_q;
        drain_d = drain_q;
        done_d  = done_q;
        nan_d   = nan_q;
        inf_d   = inf_q;
        if (wr_en) begin
            count_d = count_q + 32'd1;
            nan_d   = nan_q || (in1[33:32] == EXN_NAN);
            inf_d   = inf_q || (in1[33:32] == EXN_INF);
        end
        if (rd_en) begin
            drain_d = drain_q + 32'd1;
            if (drain_q == NelemW - 32'd1) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            drain_q <= drain_d;
            done_q  <= done_d;
            nan_q   <= nan_d;
            inf_q   <= inf_d;
        end
    end

    assign count    = count_q;
    assign done     = done_q;
    assign nan_seen = nan_q;
    assign inf_seen = inf_q;

endmodule

// File: tb/tb_coriolis_stream_sink.sv
// Randomised bench for coriolis_stream_sink: two instances (long and short run)
// share stimulus and are compared every cycle against a queue-based model.
module tb_coriolis_stream_sink;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned BIG_N   = 64;
    localparam int unsigned SMALL_N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivalid;
    logic [33:0] in1;
    logic        oready;

    logic        ir [2];
    logic        ov [2];
    logic [31:0] o1 [2];
    logic [31:0] cnt [2];
    logic        dn [2];
    logic        ns [2];
    logic        is [2];

    always #5 clk = ~clk;

    coriolis_stream_sink #(
        .STREAMW (34),
        .DATAW   (32),
        .DEPTH   (DEPTH),
        .NELEM   (BIG_N)
    ) u_dut_big (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .in1      (in1),
        .iready   (ir[0]),
        .ovalid   (ov[0]),
        .out1     (o1[0]),
        .oready   (oready),
        .count    (cnt[0]),
        .done     (dn[0]),
        .nan_seen (ns[0]),
        .inf_seen (is[0])
    );

    coriolis_stream_sink #(
        .STREAMW (34),
        .DATAW   (32),
        .DEPTH   (DEPTH),
        .NELEM   (SMALL_N)
    ) u_dut_small (
        .clk      (clk),
        .rst      (rst),
        .ivalid   (ivalid),
        .in1      (in1),
        .iready   (ir[1]),
        .ovalid   (ov[1]),
        .out1     (o1[1]),
        .oready   (oready),
        .count    (cnt[1]),
        .done     (dn[1]),
        .nan_seen (ns[1]),
        .inf_seen (is[1])
    );

    // Reference model state, one slot per instance.
    int unsigned nelem [2] = '{BIG_N, SMALL_N};
    logic [31:0] mq [2][$];
    int unsigned mcount [2];
    int unsigned mdrain [2];
    bit          mdone [2];
    bit          mnan [2];
    bit          minf [2];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ieee(input logic [33:0] w);
        logic [31:0] sign_bit;
        sign_bit = w[31] ? 32'h8000_0000 : 32'h0;
        if (w[33:32] == 2'd0) return sign_bit;
        if (w[33:32] == 2'd1) return w[31:0];
        if (w[33:32] == 2'd2) return sign_bit | 32'h7F80_0000;
        return 32'h7FC0_0000;
    endfunction

    function automatic logic [33:0] rand_word();
        logic [1:0]  exn;
        logic [31:0] bits;
        exn  = 2'($urandom_range(0, 3));
        bits = $urandom;
        return {exn, bits};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mcount[k] = 0;
            mdrain[k] = 0;
            mdone[k]  = 1'b0;
            mnan[k]   = 1'b0;
            minf[k]   = 1'b0;
        end
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit acc, rd;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            acc = ivalid && (mq[k].size() < DEPTH) && (mcount[k] < nelem[k]);
            rd  = oready && (mq[k].size() > 0);
            if (rd) begin
                void'(mq[k].pop_front());
                mdrain[k]++;
                if (mdrain[k] == nelem[k]) mdone[k] = 1'b1;
            end
            if (acc) begin
                mq[k].push_back(ref_ieee(in1));
                mcount[k]++;
                if (in1[33:32] == 2'd3) mnan[k] = 1'b1;
                if (in1[33:32] == 2'd2) minf[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        bit          exp_ir;
        logic [31:0] exp_o1;
        for (int k = 0; k < 2; k++) begin
            exp_ir = (mq[k].size() < DEPTH) && (mcount[k] < nelem[k]);
            exp_o1 = (mq[k].size() > 0) ? mq[k][0] : 32'h0;
            check_eq($sformatf("iready%0d", k), 32'(ir[k]), 32'(exp_ir));
            check_eq($sformatf("ovalid%0d", k), 32'(ov[k]), 32'(mq[k].size() > 0));
            check_eq($sformatf("out1_%0d", k), o1[k], exp_o1);
            check_eq($sformatf("count%0d", k), cnt[k], 32'(mcount[k]));
            check_eq($sformatf("done%0d", k), 32'(dn[k]), 32'(mdone[k]));
            check_eq($sformatf("nan%0d", k), 32'(ns[k]), 32'(mnan[k]));
            check_eq($sformatf("inf%0d", k), 32'(is[k]), 32'(minf[k]));
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs, advance one cycle.
    task automatic step(input logic r, input logic v, input logic [33:0] d, input logic o);
        check_all();
        rst    = r;
        ivalid = v;
        in1    = d;
        oready = o;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic random_steps(input int n, input int rst_odds);
        for (int i = 0; i < n; i++) begin
            step((rst_odds == 0) || ($urandom_range(0, rst_odds - 1) != 0),
                 $urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        rst    = 1'b0;
        ivalid = 1'b0;
        in1    = '0;
        oready = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);

        // Passthrough and exception mapping.
        step(1'b1, 1'b1, {2'b01, 32'hbd80ae10}, 1'b1);
        step(1'b1, 1'b0, 34'h0, 1'b1);
        step(1'b1, 1'b1, {2'b00, 32'h80001234}, 1'b1);
        step(1'b1, 1'b1, {2'b10, 32'h80000000}, 1'b1);
        step(1'b1, 1'b1, {2'b11, 32'h00000001}, 1'b1);
        step(1'b1, 1'b0, 34'h0, 1'b1);
        step(1'b1, 1'b0, 34'h0, 1'b1);

        random_steps(300, 0);

        // Backpressure: fill to DEPTH, then drain at full rate.
        step(1'b0, 1'b0, 34'h0, 1'b0);
        repeat (12) step(1'b1, 1'b1, rand_word(), 1'b0);
        repeat (12) step(1'b1, 1'b1, rand_word(), 1'b1);

        // Steady simultaneous read/write at occupancy 3.
        step(1'b0, 1'b0, 34'h0, 1'b0);
        repeat (3) step(1'b1, 1'b1, rand_word(), 1'b0);
        repeat (10) step(1'b1, 1'b1, rand_word(), 1'b1);

        // Reset with five words buffered.
        step(1'b0, 1'b0, 34'h0, 1'b0);
        repeat (5) step(1'b1, 1'b1, rand_word(), 1'b0);
        step(1'b0, 1'b1, rand_word(), 1'b1);
        step(1'b1, 1'b1, {2'b01, 32'h3f800000}, 1'b0);
        random_steps(30, 0);

        random_steps(500, 150);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
